// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 program loader.
package mips32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_KICK,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OVF     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Opcode field of the core's HLT instruction (bits 31:26).
  localparam logic [5:0] HLT = 6'h3f;

endpackage

// File: rtl/mips32_prog_loader.sv
// Streams a program into the core's memory from address 0, kicks the core
// with a one-cycle start pulse and supervises it until HLT or a watchdog.
module mips32_prog_loader
  import mips32_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int RUN_TIMEOUT = 4096
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              core_start,
  input  logic              core_halted,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       run_cycles
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t state, state_nx;
  logic   accept, clr_session, run_inc, set_ovf, set_to;

  // State register.
  always_ff @(posedge clk1) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic, datapath strobes and state-decoded outputs.
  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    clr_session = 1'b0;
    run_inc     = 1'b0;
    set_ovf     = 1'b0;
    set_to      = 1'b0;
    in_ready    = 1'b0;
    core_hold   = 1'b1;
    core_start  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        done = (state == ST_DONE);
        err  = (state == ST_ERR);
        if (start) begin
          state_nx    = ST_LOAD;
          clr_session = 1'b1;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          // in_last takes priority: a program that exactly fills memory is legal.
          if (in_last) begin
            state_nx = ST_FLUSH;
          end else if (word_count == (ADDR_W+1)'(DEPTH - 1)) begin
            state_nx = ST_ERR;
            set_ovf  = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        busy     = 1'b1;
        state_nx = ST_KICK;
      end
      ST_KICK: begin
        busy       = 1'b1;
        core_hold  = 1'b0;
        core_start = 1'b1;
        state_nx   = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        core_hold = 1'b0;
        // Halt beats the watchdog when both happen in the same cycle.
        if (core_halted) begin
          state_nx = ST_DONE;
        end else if (run_cycles == 32'(RUN_TIMEOUT - 1)) begin
          state_nx = ST_ERR;
          set_to   = 1'b1;
        end else begin
          run_inc = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Registered write port, session counters and error code.
  always_ff @(posedge clk1) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      run_cycles <= '0;
      err_code   <= ERR_NONE;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        mem_we     <= 1'b1;
        mem_addr   <= word_count[ADDR_W-1:0];
        mem_wdata  <= in_data;
        word_count <= word_count + (ADDR_W+1)'(1);
      end
      if (clr_session) begin
        word_count <= '0;
        run_cycles <= '0;
        err_code   <= ERR_NONE;
      end
      if (state == ST_KICK) run_cycles <= '0;
      if (run_inc && run_cycles != '1) run_cycles <= run_cycles + 32'd1;
      if (set_ovf) err_code <= ERR_OVF;
      if (set_to)  err_code <= ERR_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench: a default loader, a tiny-memory loader (overflow) and a
// short-watchdog loader (timeout) share one stimulus stream.
module tb_mips32_prog_loader;
  import mips32_pkg::*;

  logic clk1 = 1'b0;
  logic rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, core_halted = 1'b0;
  logic [31:0] in_data = '0;

  // default instance
  logic rdy_m, we_m, hold_m, cs_m, busy_m, done_m, err_m;
  logic [9:0] addr_m; logic [31:0] wdata_m, rc_m; logic [1:0] ec_m; logic [10:0] wc_m;
  // ADDR_W = 3 instance
  logic rdy_o, we_o, hold_o, cs_o, busy_o, done_o, err_o;
  logic [2:0] addr_o; logic [31:0] wdata_o, rc_o; logic [1:0] ec_o; logic [3:0] wc_o;
  // RUN_TIMEOUT = 16 instance
  logic rdy_t, we_t, hold_t, cs_t, busy_t, done_t, err_t;
  logic [9:0] addr_t; logic [31:0] wdata_t, rc_t; logic [1:0] ec_t; logic [10:0] wc_t;

  mips32_prog_loader u_main (
    .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_m),
    .in_data(in_data), .in_last(in_last), .mem_we(we_m), .mem_addr(addr_m),
    .mem_wdata(wdata_m), .core_hold(hold_m), .core_start(cs_m), .core_halted(core_halted),
    .busy(busy_m), .done(done_m), .err(err_m), .err_code(ec_m), .word_count(wc_m),
    .run_cycles(rc_m));

  mips32_prog_loader #(.ADDR_W(3)) u_ovf (
    .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_o),
    .in_data(in_data), .in_last(in_last), .mem_we(we_o), .mem_addr(addr_o),
    .mem_wdata(wdata_o), .core_hold(hold_o), .core_start(cs_o), .core_halted(core_halted),
    .busy(busy_o), .done(done_o), .err(err_o), .err_code(ec_o), .word_count(wc_o),
    .run_cycles(rc_o));

  mips32_prog_loader #(.RUN_TIMEOUT(16)) u_to (
    .clk1(clk1), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy_t),
    .in_data(in_data), .in_last(in_last), .mem_we(we_t), .mem_addr(addr_t),
    .mem_wdata(wdata_t), .core_hold(hold_t), .core_start(cs_t), .core_halted(core_halted),
    .busy(busy_t), .done(done_t), .err(err_t), .err_code(ec_t), .word_count(wc_t),
    .run_cycles(rc_t));

  always #5 clk1 = ~clk1;

  logic [31:0] prog [9] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                            32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                            32'hfc000000};

  int n_chk = 0, n_pass = 0;
  int cyc = 0, we_err = 0, n_start_m = 0, n_start_o = 0, start_cyc = 0, last_hs_cyc = 0;
  logic hs_prev = 1'b0;
  logic [9:0]  wa_q[$]; logic [31:0] wd_q[$];
  logic [2:0]  wa_o[$]; logic [31:0] wd_o[$];

  always @(posedge clk1) cyc <= cyc + 1;

  // Write/start monitor, sampled mid-cycle.
  always @(negedge clk1) begin
    if (we_m) begin wa_q.push_back(addr_m); wd_q.push_back(wdata_m); end
    if (we_o) begin wa_o.push_back(addr_o); wd_o.push_back(wdata_o); end
    if (we_m !== hs_prev) we_err <= we_err + 1;
    hs_prev <= in_valid & rdy_m & ~rst;
    if (in_valid & rdy_m & in_last & ~rst) last_hs_cyc <= cyc;
    if (cs_m) begin n_start_m <= n_start_m + 1; start_cyc <= cyc; end
    if (cs_o) n_start_o <= n_start_o + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk1); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!rdy_m && n < 50) begin tick(); n++; end
    if (!rdy_m) chk("ready_wait", rdy_m, 1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic load_prog(input int max_gap);
    for (int i = 0; i < 9; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
      send(prog[i], i == 8);
    end
  endtask

  task automatic wait_rc(input int v);
    int n = 0;
    while (rc_m != 32'(v) && n < 200) begin tick(); n++; end
    chk("run_reach", rc_m, v);
  endtask

  task automatic check_image(input int base, input int n);
    chk("wr_count", wa_q.size() - base, n);
    for (int i = 0; i < n && base + i < wa_q.size(); i++) begin
      chk("wr_addr", wa_q[base+i], i);
      chk("wr_data", wd_q[base+i], prog[i]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    // Reset values
    tick(); tick();
    chk("rst_ready", rdy_m, 0);   chk("rst_we", we_m, 0);     chk("rst_cs", cs_m, 0);
    chk("rst_busy", busy_m, 0);   chk("rst_done", done_m, 0); chk("rst_err", err_m, 0);
    chk("rst_hold", hold_m, 1);   chk("rst_addr", addr_m, 0); chk("rst_wdata", wdata_m, 0);
    chk("rst_ec", ec_m, 0);       chk("rst_wc", wc_m, 0);     chk("rst_rc", rc_m, 0);
    rst = 1'b0; tick();

    // Back-to-back load, halt at run cycle 30
    pulse_start();
    chk("load_busy", busy_m, 1);
    chk("load_ready", rdy_m, 1);
    load_prog(0);
    chk("flush_hold", hold_m, 1);
    chk("flush_cs", cs_m, 0);
    tick();
    chk("kick_cs", cs_m, 1);
    chk("kick_hold", hold_m, 0);
    wait_rc(30);
    core_halted = 1'b1; tick(); core_halted = 1'b0;
    chk("done", done_m, 1);        chk("done_rc", rc_m, 30);
    chk("done_busy", busy_m, 0);   chk("done_hold", hold_m, 1);
    chk("wc9", wc_m, 9);           chk("kick_gap", start_cyc - last_hs_cyc, 2);
    chk("n_start", n_start_m, 1);  chk("last_is_hlt", wd_q[wd_q.size()-1][31:26], HLT);
    check_image(0, 9);
    tick();
    chk("done_hold_rc", rc_m, 30);
    chk("done_sticky", done_m, 1);

    // Overflow instance: 8 writes, then ERR/01
    chk("ovf_err", err_o, 1);      chk("ovf_ec", ec_o, ERR_OVF);
    chk("ovf_ready", rdy_o, 0);    chk("ovf_wc", wc_o, 8);
    chk("ovf_nstart", n_start_o, 0);
    chk("ovf_wcount", wa_o.size(), 8);
    for (int i = 0; i < 8 && i < wa_o.size(); i++) begin
      chk("ovf_addr", wa_o[i], i);
      chk("ovf_data", wd_o[i], prog[i]);
    end

    // Timeout instance: ERR/10 at run cycle 15
    chk("to_err", err_t, 1);       chk("to_ec", ec_t, ERR_TIMEOUT);
    chk("to_rc", rc_t, 15);        chk("to_hold", hold_t, 1);
    chk("to_done", done_t, 0);

    // Restart from DONE with random gaps; start during RUN ignored
    base = wa_q.size();
    pulse_start();
    chk("re_done_clr", done_m, 0); chk("re_wc_clr", wc_m, 0);
    chk("re_rc_clr", rc_m, 0);     chk("re_busy", busy_m, 1);
    load_prog(3);
    tick(); tick();
    wait_rc(5);
    pulse_start();
    chk("run_start_busy", busy_m, 1);
    chk("run_start_rc", rc_m, 6);
    chk("run_start_wc", wc_m, 9);
    wait_rc(10);
    core_halted = 1'b1; tick(); core_halted = 1'b0;
    chk("re_done", done_m, 1);     chk("re_rc", rc_m, 10);
    chk("re_wc", wc_m, 9);
    check_image(base, 9);
    chk("no_spurious_we", we_err, 0);

    // Reset after 4 words of load, then reload from address 0
    base = wa_q.size();
    pulse_start();
    for (int i = 0; i < 4; i++) send(prog[i], 1'b0);
    in_valid = 1'b1; in_data = prog[4];
    rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_busy", busy_m, 0);   chk("mrst_ready", rdy_m, 0);
    chk("mrst_we", we_m, 0);       chk("mrst_hold", hold_m, 1);
    chk("mrst_wc", wc_m, 0);       chk("mrst_addr", addr_m, 0);
    chk("mrst_wdata", wdata_m, 0); chk("mrst_ec", ec_m, 0);
    tick(); tick();
    chk("mrst_writes", wa_q.size() - base, 4);
    base = wa_q.size();
    core_halted = 1'b1;            // ignored until RUN
    pulse_start();
    load_prog(1);
    chk("halt_ign_busy", busy_m, 1);
    tick(); tick();                // KICK, then RUN samples halt
    chk("rl_busy", busy_m, 1);
    tick();
    core_halted = 1'b0;
    chk("rl_done", done_m, 1);     chk("rl_rc", rc_m, 0);
    chk("rl_wc", wc_m, 9);
    check_image(base, 9);
    chk("no_spurious_we2", we_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Program loader and run supervisor placed directly upstream of the `pipe_MIPS32` core.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the core's memory starting at address 0.
- Holds the core off while loading, then issues a one-cycle start pulse; the core responds by clearing `HALTED` and `TAKEN_BRANCH` and setting `PC` = 0.
- Supervises execution until the core reports halt (HLT executed) or a watchdog expires.

## Interface
Parameters:
- `ADDR_W`, 10, memory word-address width; program capacity `DEPTH` = 2**`ADDR_W` words.
- `RUN_TIMEOUT`, 4096, maximum RUN cycles before a timeout error.

Ports:
- `clk1`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin load session; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  instruction word valid.
- `in_ready`  out  1  loader accepts a word.
- `in_data`  in  32  instruction word.
- `in_last`  in  1  final word of the program.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  `ADDR_W`  memory write address.
- `mem_wdata`  out  32  memory write data.
- `core_hold`  out  1  core must stay halted while high.
- `core_start`  out  1  one-cycle pulse; core clears `HALTED`/`TAKEN_BRANCH` and sets `PC` = 0.
- `core_halted`  in  1  core `HALTED` flag.
- `busy`  out  1  session in progress.
- `done`  out  1  program ran to HLT.
- `err`  out  1  session failed.
- `err_code`  out  2  00 none, 01 overflow, 10 timeout.
- `word_count`  out  `ADDR_W`+1  words accepted this session.
- `run_cycles`  out  32  RUN cycles elapsed.

## Operation
States: IDLE, LOAD, FLUSH, KICK, RUN, DONE, ERR.

Transitions:
- IDLE/DONE/ERR + `start`: go to LOAD; clear `word_count`, `run_cycles`, `err_code`, `done`, `err`; write pointer = 0.
- LOAD: `in_ready` = 1. On handshake (`in_valid` & `in_ready`):
  - capture word; write pointer +1; `word_count` +1.
  - if `in_last`: go to FLUSH.
  - else if this was word number `DEPTH`: go to ERR with code 01.
- FLUSH: one cycle while the final write completes; then go to KICK.
- KICK: `core_start` = 1 for exactly one cycle; `run_cycles` cleared; then go to RUN.
- RUN, checked each cycle:
  - `core_halted` = 1: go to DONE.
  - else if `run_cycles` == `RUN_TIMEOUT`-1: go to ERR with code 10.
  - else `run_cycles` +1.
  - Halt wins when halt and timeout coincide.

Outputs and side rules:
- `core_hold` = 0 in KICK and RUN; 1 in all other states.
- `busy` = 1 in LOAD, FLUSH, KICK, RUN.
- `done`/`err` hold until the next `start` or `rst`.
- `start` in LOAD, FLUSH, KICK or RUN is ignored.
- `core_halted` is ignored outside RUN.
- `in_ready` = 0 outside LOAD; words are never dropped or duplicated.

## Timing
- Handshake at cycle t: `mem_we` = 1 at t+1 with `mem_addr` = index, `mem_wdata` = word. All three are registered.
- `in_last` handshake at t: FLUSH at t+1 (last write visible), KICK/`core_start` at t+2, RUN at t+3.
- Overflow: the `DEPTH`-th word is written at t+1; ERR from t+1 on; `in_ready` is low from t+1.
- `done` is asserted the cycle after `core_halted` is sampled high in RUN.
- Reset values:
  - state IDLE;
  - `in_ready`, `mem_we`, `core_start`, `busy`, `done`, `err` = 0;
  - `core_hold` = 1;
  - `mem_addr`, `mem_wdata`, `err_code`, `word_count`, `run_cycles` = 0.
- `rst` mid-session aborts on the next edge. The write pipeline is discarded; no `mem_we` in the cycle after reset.
- `run_cycles` saturates at 2**32-1; it holds its value in DONE and ERR.

## Structure
- Package `mips32_pkg`: state enum, error-code constants (`ERR_NONE`, `ERR_OVF`, `ERR_TIMEOUT`), `HLT` opcode 6'h3f for bench checks.
- Single module; no sub-module warranted. Counters and FSM are inline.

## Test plan
- Nine-word program (`2801000a`, `28020014`, `28030019`, `0ce77800`, `0ce77800`, `00222000`, `0ce77800`, `00832800`, `fc000000`) with `in_last` on word 9:
  - writes to addresses 0..8 with matching data;
  - `word_count` = 9;
  - `core_start` exactly 2 cycles after the last handshake;
  - `core_halted` at run cycle 30 -> `done` = 1, `run_cycles` = 30.
- Random `in_valid` gaps during load -> identical memory image and count; no write in a cycle without a handshake.
- `ADDR_W` = 3, nine words without `in_last` -> 8 writes (addresses 0..7), `err` = 1, `err_code` = 01, `in_ready` low afterwards, no `core_start`.
- `RUN_TIMEOUT` = 16, `core_halted` held 0 -> ERR, `err_code` = 10, `run_cycles` = 15, `core_hold` = 1.
- `rst` after 4 words of LOAD -> IDLE next cycle, all outputs at reset values, no further writes. A following `start` reloads from address 0.
- `start` pulsed during RUN is ignored. `start` from DONE clears `done`, `word_count` and `run_cycles` and reloads.
